// File: rtl/fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// fetch_unit_pkg
//   Shared definitions for the instruction-fetch front end: the NOP encoding
//   used to fill an invalidated IF/ID slot, the default reset vector, the
//   fetch FSM state type and the sequential-PC helper.
// -----------------------------------------------------------------------------
package fetch_unit_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_REQ  = 2'd0,  // free to issue a request
        F_WAIT = 2'd1,  // one request outstanding, its data is wanted
        F_DROP = 2'd2   // one request outstanding, its data is wrong-path
    } fetch_state_t;

    // Sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   Pipeline register between fetch and decode. Priority flush > stall > load.
//   A flush invalidates the slot and parks a NOP in it. When neither stalled
//   nor loaded the slot turns into a bubble so decode never sees an
//   instruction twice.
//
//   clk, reset       : clock, synchronous active-low reset
//   i_flush          : invalidate the slot
//   i_stall          : keep the current contents
//   i_load           : capture i_instr / i_pc
//   i_instr, i_pc    : incoming instruction word and its address
//   o_instr, o_pc    : registered instruction and address
//   o_pc_plus4       : registered o_pc + 4
//   o_valid          : slot holds a live instruction
// -----------------------------------------------------------------------------
module if_id_reg
    import fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_stall,
    input  logic        i_load,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_pc       <= 32'd0;
            r_pc_plus4 <= 32'd0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_instr <= NOP_INSTR;
        end else if (!i_stall) begin
            if (i_load) begin
                r_valid    <= 1'b1;
                r_instr    <= i_instr;
                r_pc       <= i_pc;
                r_pc_plus4 <= pc_next(i_pc);
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end. Owns the fetch PC, keeps at most one request
//   outstanding on the instruction-memory channel, parks a response that
//   arrives while decode is stalled in a one-entry hold buffer, and feeds the
//   IF/ID register.
//
//   clk, reset            : clock, synchronous active-low reset
//   stallF                : freeze the fetch PC, issue nothing new
//   stallD / flushD       : hold / invalidate the IF/ID register
//   branch_sig            : redirect fetch to branch_target
//   branch_target         : redirect address (word aligned)
//   imem_req_valid/ready  : request handshake, address on imem_req_addr
//   imem_resp_valid/data  : response, one per accepted request, >= 1 cycle later
//   instrD, pcD,
//   pc_plus4D, validD     : IF/ID register contents
//   imem_stall            : fetch could not deliver an instruction this cycle
// -----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushD,
    input  logic        branch_sig,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] instrD,
    output logic [31:0] pcD,
    output logic [31:0] pc_plus4D,
    output logic        validD,
    output logic        imem_stall
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pcF;
    logic [31:0] w_pcF_nxt;
    logic [31:0] r_req_pc;       // address of the outstanding request
    logic [31:0] w_req_pc_nxt;

    logic        r_hold_valid;
    logic        w_hold_valid_nxt;
    logic        w_hold_we;
    logic [31:0] r_hold_instr;
    logic [31:0] r_hold_pc;

    logic        w_req_raw;
    logic        w_req_valid;
    logic        w_load;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc;

    // ---------------------------------------------------------------------
    // Next-state, request and IF/ID-load decisions
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_pcF_nxt        = r_pcF;
        w_req_pc_nxt     = r_req_pc;
        w_hold_valid_nxt = r_hold_valid;
        w_hold_we        = 1'b0;
        w_req_raw        = 1'b0;
        w_load           = 1'b0;
        w_load_instr     = imem_resp_data;
        w_load_pc        = r_req_pc;

        case (r_state)
            F_REQ: begin
                w_req_raw = ~stallF & ~r_hold_valid & ~branch_sig;
                // A parked instruction drains once decode frees up; a
                // redirect makes it wrong-path, so it is dropped instead.
                if (r_hold_valid && !stallD && !branch_sig) begin
                    w_load           = 1'b1;
                    w_load_instr     = r_hold_instr;
                    w_load_pc        = r_hold_pc;
                    w_hold_valid_nxt = 1'b0;
                end
            end
            F_WAIT: begin
                if (branch_sig) begin
                    // A response in the redirect cycle is simply discarded and
                    // nothing is left outstanding; otherwise the late one must
                    // be swallowed in DROP.
                    w_state_nxt = imem_resp_valid ? F_REQ : F_DROP;
                end else if (imem_resp_valid) begin
                    if (!stallD) begin
                        w_load    = 1'b1;
                        // Back-to-back request keeps 1 IPC with 1-cycle memory.
                        w_req_raw = ~stallF;
                    end else begin
                        w_hold_we        = 1'b1;
                        w_hold_valid_nxt = 1'b1;
                    end
                    w_state_nxt = F_REQ;
                end
            end
            F_DROP: begin
                if (imem_resp_valid) begin
                    w_state_nxt = F_REQ;
                end
            end
            default: begin
                w_state_nxt = F_REQ;
            end
        endcase

        // Nothing leaves the unit while reset is held, whatever the state.
        w_req_valid = w_req_raw & reset;

        if (w_req_valid && imem_req_ready) begin
            w_pcF_nxt    = pc_next(r_pcF);
            w_req_pc_nxt = r_pcF;
            w_state_nxt  = F_WAIT;
        end

        // Requests are masked during a redirect, so this never collides with
        // the handshake above.
        if (branch_sig) begin
            w_pcF_nxt        = branch_target;
            w_hold_valid_nxt = 1'b0;
        end
    end

    // ---------------------------------------------------------------------
    // FSM and fetch-side state
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= F_REQ;
            r_pcF        <= RESET_PC;
            r_hold_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcF        <= w_pcF_nxt;
            r_hold_valid <= w_hold_valid_nxt;
        end
    end

    always_ff @(posedge clk) begin
        r_req_pc <= w_req_pc_nxt;
        if (w_hold_we) begin
            r_hold_instr <= imem_resp_data;
            r_hold_pc    <= r_req_pc;
        end
    end

    // ---------------------------------------------------------------------
    // IF/ID register
    // ---------------------------------------------------------------------
    if_id_reg u_if_id (
        .clk        (clk),
        .reset      (reset),
        .i_flush    (flushD),
        .i_stall    (stallD),
        .i_load     (w_load),
        .i_instr    (w_load_instr),
        .i_pc       (w_load_pc),
        .o_instr    (instrD),
        .o_pc       (pcD),
        .o_pc_plus4 (pc_plus4D),
        .o_valid    (validD)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pcF;
    assign imem_stall     = reset & (((r_state == F_WAIT) & ~imem_resp_valid) |
                                     (r_state == F_DROP) |
                                     (w_req_valid & ~imem_req_ready));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RST = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset, stallF, stallD, flushD, branch_sig;
    logic [31:0] branch_target;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic [31:0] instrD, pcD, pc_plus4D;
    logic        validD, imem_stall;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 1;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST)) dut (
        .clk            (clk),
        .reset          (reset),
        .stallF         (stallF),
        .stallD         (stallD),
        .flushD         (flushD),
        .branch_sig     (branch_sig),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instrD         (instrD),
        .pcD            (pcD),
        .pc_plus4D      (pc_plus4D),
        .validD         (validD),
        .imem_stall     (imem_stall)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(negedge clk);
    endtask

    // Instruction memory: one pending request, answers lat cycles after acceptance.
    initial begin : memory
        logic        m_pend;
        logic [31:0] m_addr;
        int          m_cnt;
        m_pend = 1'b0; m_addr = 32'd0; m_cnt = 0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (reset && imem_req_valid && imem_req_ready) begin
                m_pend = 1'b1;
                m_addr = imem_req_addr;
                m_cnt  = lat;
            end
            @(posedge clk);
            #1;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'hDEAD_BEEF;
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = memfn(m_addr);
                    m_pend = 1'b0;
                end
            end
        end
    end

    // Program-order model: what decode should see next, where fetch should
    // ask next, and whether a wrong-path response is still in flight.
    initial begin : compare
        logic [31:0] exp_pc, fetch_pc, prev_addr, s_target, s_addr;
        logic        outstanding, drop_pending, prev_wait, exp_stall;
        logic        s_reset, s_hs, s_resp, s_branch, s_vld, s_stallD, s_flushD, s_req, s_ready;
        exp_pc = RST; fetch_pc = RST; prev_addr = 32'd0;
        outstanding = 1'b0; drop_pending = 1'b0; prev_wait = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk1("stall_in_reset", imem_stall, 1'b0);
            end else begin
                exp_stall = (outstanding && (!imem_resp_valid || drop_pending)) ||
                            (imem_req_valid && !imem_req_ready);
                chk1("imem_stall", imem_stall, exp_stall);
                if (validD) begin
                    chk("pcD_order", pcD, exp_pc);
                    chk("instrD_data", instrD, memfn(pcD));
                    chk("pc_plus4D", pc_plus4D, pcD + 32'd4);
                end
                if (imem_req_valid) begin
                    chk("req_addr", imem_req_addr, fetch_pc);
                    chk1("req_single_outstanding",
                         !outstanding || (imem_resp_valid && !drop_pending), 1'b1);
                    chk1("req_gated", !stallF && !branch_sig, 1'b1);
                    if (prev_wait) chk("req_addr_stable", imem_req_addr, prev_addr);
                end
            end
            s_reset  = reset;
            s_hs     = imem_req_valid && imem_req_ready;
            s_resp   = imem_resp_valid;
            s_branch = branch_sig;
            s_target = branch_target;
            s_vld    = validD;
            s_stallD = stallD;
            s_flushD = flushD;
            s_req    = imem_req_valid;
            s_ready  = imem_req_ready;
            s_addr   = imem_req_addr;
            @(posedge clk);
            if (!s_reset) begin
                exp_pc = RST; fetch_pc = RST;
                outstanding = 1'b0; drop_pending = 1'b0; prev_wait = 1'b0;
            end else begin
                if (s_resp && outstanding) begin
                    outstanding  = 1'b0;
                    drop_pending = 1'b0;
                end
                if (s_hs) begin
                    outstanding = 1'b1;
                    fetch_pc    = fetch_pc + 32'd4;
                end
                if (s_branch) begin
                    fetch_pc = s_target;
                    exp_pc   = s_target;
                    if (outstanding) drop_pending = 1'b1;
                end else if (s_vld && !s_stallD && !s_flushD) begin
                    exp_pc = exp_pc + 32'd4;
                end
                prev_wait = s_req && !s_ready && !s_branch;
                prev_addr = s_addr;
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin : stim
        int ns, nv;
        reset = 1'b0; stallF = 1'b0; stallD = 1'b0; flushD = 1'b0;
        branch_sig = 1'b0; branch_target = 32'd0; imem_req_ready = 1'b1; lat = 1;

        // Reset state
        probe();
        chk1("rst_validD", validD, 1'b0);
        chk("rst_instrD", instrD, NOP);
        chk("rst_pcD", pcD, 32'd0);
        chk("rst_pc_plus4D", pc_plus4D, 32'd0);
        step(); probe();
        chk1("rst_stall", imem_stall, 1'b0);
        chk1("rst_no_req", imem_req_valid, 1'b0);

        // 1-cycle memory, 1 IPC
        step(); reset = 1'b1; probe();                       // c0
        chk1("c0_req", imem_req_valid, 1'b1);
        chk("c0_addr", imem_req_addr, 32'h0);
        step(); probe();                                     // c1
        chk("c1_addr", imem_req_addr, 32'h4);
        chk1("c1_validD", validD, 1'b0);
        step(); probe();                                     // c2
        chk1("c2_validD", validD, 1'b1);
        chk("c2_pcD", pcD, 32'h0);
        chk("c2_instrD", instrD, 32'hA5A5_0000);
        step(); probe();                                     // c3
        chk("c3_pcD", pcD, 32'h4);
        step(); probe();                                     // c4
        chk("c4_pcD", pcD, 32'h8);
        chk1("c4_stall", imem_stall, 1'b0);

        // 3-cycle memory: 2 stall cycles and 1 instruction per fetch
        step(); lat = 3; probe();                            // c5
        step(); probe();                                     // c6
        step(); probe();                                     // c7
        ns = 0; nv = 0;
        for (int i = 0; i < 12; i++) begin                   // c8..c19
            step(); probe();
            if (imem_stall) ns++;
            if (validD) nv++;
        end
        chk("lat3_stall_cycles", ns, 8);
        chk("lat3_valid_cycles", nv, 4);
        step(); probe();                                     // c20: accepted 0x28
        chk1("c20_req", imem_req_valid, 1'b1);
        chk("c20_addr", imem_req_addr, 32'h28);

        // Reset mid-WAIT; the late response must be ignored
        step(); reset = 1'b0; probe();                       // c21
        chk1("midrst_stall", imem_stall, 1'b0);
        step(); reset = 1'b1; imem_req_ready = 1'b0; probe(); // c22
        chk1("midrst_validD", validD, 1'b0);
        chk("midrst_instrD", instrD, NOP);
        step(); probe();                                     // c23: stale response
        step(); probe();                                     // c24
        chk1("stale_ignored", validD, 1'b0);
        step(); imem_req_ready = 1'b1; lat = 1; probe();     // 0'
        chk1("post_rst_req", imem_req_valid, 1'b1);
        chk("post_rst_addr", imem_req_addr, RST);

        // Redirect to 0x100 while waiting on 0x8
        step(); probe();                                     // 1'
        step(); lat = 3; probe();                            // 2'
        chk("p2_addr", imem_req_addr, 32'h8);
        step(); branch_sig = 1'b1; branch_target = 32'h100; flushD = 1'b1; probe(); // 3'
        chk("p3_pcD", pcD, 32'h4);
        chk1("p3_stall", imem_stall, 1'b1);
        step(); branch_sig = 1'b0; flushD = 1'b0; lat = 1; probe();                 // 4'
        chk1("flush_validD", validD, 1'b0);
        chk("flush_instrD", instrD, NOP);
        chk1("drop_stall", imem_stall, 1'b1);
        step(); probe();                                     // 5': 0x8 data dropped
        chk1("drop_no_req", imem_req_valid, 1'b0);
        step(); probe();                                     // 6'
        chk("redir_addr", imem_req_addr, 32'h100);
        for (int i = 0; i < 2; i++) begin                    // 7', 8'
            step(); probe();
            chk1("no_dropped_data", instrD == memfn(32'h8), 1'b0);
        end
        chk("redir_pcD", pcD, 32'h100);
        chk("redir_instrD", instrD, memfn(32'h100));

        // Response lands in hold while decode is stalled
        step(); stallD = 1'b1; probe();                      // 9'
        chk1("hold_no_req0", imem_req_valid, 1'b0);
        chk("hold_pcD0", pcD, 32'h104);
        step(); probe();                                     // 10'
        chk1("hold_no_req1", imem_req_valid, 1'b0);
        chk("hold_pcD1", pcD, 32'h104);
        step(); stallD = 1'b0; probe();                      // 11'
        chk1("hold_no_req2", imem_req_valid, 1'b0);

        // flushD + stallD + branch + stallF together
        step(); branch_sig = 1'b1; branch_target = 32'h200; flushD = 1'b1; stallD = 1'b1; stallF = 1'b1; probe(); // 12'
        chk("hold_drained_pcD", pcD, 32'h108);
        chk("hold_drained_instrD", instrD, memfn(32'h108));
        chk1("branch_masks_req", imem_req_valid, 1'b0);
        step(); branch_sig = 1'b0; flushD = 1'b0; stallD = 1'b0; stallF = 1'b0; probe(); // 13'
        chk1("fs_validD", validD, 1'b0);
        chk("fs_instrD", instrD, NOP);
        chk("fs_redir_addr", imem_req_addr, 32'h200);
        step(); probe();                                     // 14'
        step(); probe();                                     // 15'
        chk("p15_pcD", pcD, 32'h200);

        // PC wrap at 2^32
        step(); branch_sig = 1'b1; branch_target = 32'hFFFF_FFF8; flushD = 1'b1; probe(); // 16'
        step(); branch_sig = 1'b0; flushD = 1'b0; probe();   // 17'
        chk("wrap_addr0", imem_req_addr, 32'hFFFF_FFF8);
        step(); probe();                                     // 18'
        step(); probe();                                     // 19'
        chk("wrap_addr2", imem_req_addr, 32'h0);
        step(); probe();                                     // 20'
        chk("wrap_pcD", pcD, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4D", pc_plus4D, 32'h0);
        step(); probe();                                     // 21'
        chk("wrap_pcD2", pcD, 32'h0);

        // stallF keeps the outstanding response
        step(); stallF = 1'b1; probe();                      // 22'
        chk1("stallF_no_req", imem_req_valid, 1'b0);
        step(); probe();                                     // 23'
        chk("stallF_pcD", pcD, 32'h8);
        chk1("stallF_stall", imem_stall, 1'b0);
        step(); probe();                                     // 24'
        step(); stallF = 1'b0; probe();                      // 25'
        chk("stallF_resume", imem_req_addr, 32'hC);
        repeat (4) begin
            step(); probe();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
